// File: rtl/router_ctrl_fsm_pkg.sv
// Shared definitions for the router control FSM: state encoding, default sizing,
// and the Moore output decode reused by the register and synchronizer blocks.
package router_ctrl_fsm_pkg;

    localparam int NUM_PORTS_DEF = 3;
    localparam int ADDR_W_DEF    = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_e;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
    } ctrl_out_t;

    function automatic ctrl_out_t decode_outputs(input state_e s);
        ctrl_out_t o;
        o = '0;
        case (s)
            DECODE_ADDRESS:     o.detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                o.lfd_state = 1'b1;
                o.busy      = 1'b1;
            end
            LOAD_DATA: begin
                o.ld_state      = 1'b1;
                o.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                o.full_state = 1'b1;
                o.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                o.laf_state     = 1'b1;
                o.write_enb_reg = 1'b1;
                o.busy          = 1'b1;
            end
            LOAD_PARITY: begin
                o.write_enb_reg = 1'b1;
                o.busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                o.rst_int_reg = 1'b1;
                o.busy        = 1'b1;
            end
            WAIT_TILL_EMPTY:    o.busy = 1'b1;
            default:            o.detect_add = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Control bus between the router FSM and its neighbours (source, register block,
// synchronizer/FIFO bank). The FSM is the slave side; everything else is master.
interface router_ctrl_fsm_if
    import router_ctrl_fsm_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
);

    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 parity_done;
    logic                 low_pkt_valid;

    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 write_enb_reg;
    logic                 busy;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy
    );

endinterface

// File: rtl/router_ctrl_fsm.sv
// Router control FSM: decodes the header address, waits for the destination FIFO,
// and sequences the load strobes and source back-pressure. Moore outputs only.
module router_ctrl_fsm
    import router_ctrl_fsm_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
)(
    input  logic clk,
    input  logic resetn,
    router_ctrl_fsm_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid;
    ctrl_out_t         outs;

    // Bounded per-port select; an out-of-range index reads as 0.
    function automatic logic sel_bit(input logic [NUM_PORTS-1:0] vec,
                                     input logic [ADDR_W-1:0]    idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (int'(idx) == i) r = vec[i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_valid = bus.pkt_valid && (int'(bus.data_in) < NUM_PORTS);

        if (state_q != DECODE_ADDRESS && sel_bit(bus.soft_reset, addr_q)) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (addr_valid) begin
                        addr_d  = bus.data_in;
                        state_d = sel_bit(bus.fifo_empty, bus.data_in) ?
                                  LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_bit(bus.fifo_empty, addr_q)) state_d = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        state_d = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                    else                        state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    assign outs              = decode_outputs(state_q);
    assign bus.detect_add    = outs.detect_add;
    assign bus.lfd_state     = outs.lfd_state;
    assign bus.ld_state      = outs.ld_state;
    assign bus.laf_state     = outs.laf_state;
    assign bus.full_state    = outs.full_state;
    assign bus.rst_int_reg   = outs.rst_int_reg;
    assign bus.write_enb_reg = outs.write_enb_reg;
    assign bus.busy          = outs.busy;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: a vector table for the main packet flows
// and hand-written sequences for invalid address, soft reset and mid-packet reset.
module tb_router_ctrl_fsm;

    // Output vector order: detect_add, lfd, ld, laf, full, rst_int, wen, busy
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0010;
    localparam logic [7:0] O_LAF = 8'b0001_0011;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LP  = 8'b0000_0011;
    localparam logic [7:0] O_CPE = 8'b0000_0101;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    typedef struct {
        logic       rstn;
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] empty;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    vec_t vecs[$];

    router_ctrl_fsm_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();

    router_ctrl_fsm #(.NUM_PORTS(3), .ADDR_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs_now();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rstn, input logic pv, input logic [1:0] din,
                         input logic full, input logic [2:0] empty, input logic [2:0] sr,
                         input logic pd, input logic lpv);
        resetn            = rstn;
        bus.pkt_valid     = pv;
        bus.data_in       = din;
        bus.fifo_full     = full;
        bus.fifo_empty    = empty;
        bus.soft_reset    = sr;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rstn, input logic pv, input logic [1:0] din,
                       input logic full, input logic [2:0] empty, input logic [2:0] sr,
                       input logic pd, input logic lpv, input logic [7:0] exp);
        vec_t v;
        v.rstn = rstn; v.pv = pv; v.din = din; v.full = full; v.empty = empty;
        v.sr = sr; v.pd = pd; v.lpv = lpv; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One hand-written step: drive, clock, compare outputs
    task automatic hs(input string name, input logic rstn, input logic pv,
                      input logic [1:0] din, input logic full, input logic [2:0] empty,
                      input logic [2:0] sr, input logic [7:0] exp);
        drive(rstn, pv, din, full, empty, sr, 1'b0, 1'b0);
        step();
        check8(name, outs_now(), exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);

        //   rstn pv din full empty   sr      pd lpv expected
        add(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA);   // reset
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA);   // idle
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA);
        add(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LFD);  // header port 1
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LP);   // parity byte
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE);
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA);
        add(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE);  // header port 2, not empty
        add(1, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE);
        add(1, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE);
        add(1, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE);
        add(1, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS);  // full for 3 cycles
        add(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS);
        add(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1, O_LP);   // low_pkt_valid path
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE);
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DA);
        add(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FFS);
        add(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
        add(1, 0, 2'd0, 0, 3'b111, 3'b000, 1, 0, O_DA);   // parity_done path

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rstn, vecs[i].pv, vecs[i].din, vecs[i].full,
                  vecs[i].empty, vecs[i].sr, vecs[i].pd, vecs[i].lpv);
            step();
            check8($sformatf("vec%0d", i), outs_now(), vecs[i].exp);
        end

        // Invalid address and pkt_valid low both leave addr_q at 2
        hs("inv_addr3",   1, 1, 2'd3, 0, 3'b111, 3'b000, O_DA);
        check8("inv_addr3_addr", {6'd0, dut.addr_q}, 8'd2);
        hs("pv_low_hdr",  1, 0, 2'd1, 0, 3'b111, 3'b000, O_DA);
        check8("pv_low_addr", {6'd0, dut.addr_q}, 8'd2);

        // Soft reset: only the selected port counts, and not in DECODE
        hs("wte_p0",      1, 1, 2'd0, 0, 3'b110, 3'b000, O_WTE);
        hs("sr_other",    1, 0, 2'd0, 0, 3'b110, 3'b010, O_WTE);
        hs("sr_sel",      1, 0, 2'd0, 0, 3'b110, 3'b001, O_DA);
        hs("sr_in_da",    1, 1, 2'd1, 0, 3'b111, 3'b001, O_LFD);
        hs("lfd_to_ld",   1, 1, 2'd0, 0, 3'b111, 3'b000, O_LD);
        hs("sr_in_ld",    1, 1, 2'd0, 0, 3'b111, 3'b010, O_DA);

        // CPE with FIFO full, then reset while in FIFO_FULL_STATE
        hs("c_lfd",       1, 1, 2'd0, 0, 3'b111, 3'b000, O_LFD);
        check8("c_addr0", {6'd0, dut.addr_q}, 8'd0);
        hs("c_ld",        1, 1, 2'd0, 0, 3'b111, 3'b000, O_LD);
        hs("c_lp",        1, 0, 2'd0, 0, 3'b111, 3'b000, O_LP);
        hs("c_cpe",       1, 0, 2'd0, 1, 3'b111, 3'b000, O_CPE);
        hs("cpe_full",    1, 0, 2'd0, 1, 3'b111, 3'b000, O_FFS);
        hs("rst_in_ffs",  0, 0, 2'd0, 1, 3'b111, 3'b000, O_DA);
        hs("post_rst",    1, 0, 2'd0, 0, 3'b111, 3'b000, O_DA);

        // Reset clears a non-zero captured address
        hs("hdr_p2",      1, 1, 2'd2, 0, 3'b111, 3'b000, O_LFD);
        hs("rst_lfd",     0, 0, 2'd0, 0, 3'b111, 3'b000, O_DA);
        check8("rst_addr", {6'd0, dut.addr_q}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
